// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the sized data memory.
// Size codes, FSM state type and the byte-enable generator.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  // Byte enables for an access of `size` starting at byte `lane`; callers keep the low DATA_W/8 bits.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] lane);
    logic [7:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: picks the addressed lanes out of a memory word and
// sign- or zero-extends them to the full data width.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]             word,
  input  logic [$clog2(DATA_W/8)-1:0]   lane,
  input  logic [1:0]                    size,
  input  logic                          unsigned_ld,
  output logic [DATA_W-1:0]             result
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: result = unsigned_ld ? DATA_W'(shifted[7:0])  : DATA_W'($signed(shifted[7:0]));
      SZ_HALF: result = unsigned_ld ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
      SZ_WORD: result = unsigned_ld ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// MEM-stage data memory: byte/half/word(/dword) loads and stores, registered reads,
// misalignment flagging and a self-clearing INIT pass. Optional DMEM_PARITY_EN adds per-byte parity.
module data_memory_sized
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  output logic [DATA_W-1:0] readdata,
  output logic              rdvalid,
  output logic              ready,
  output logic              misalign
`ifdef DMEM_PARITY_EN
  ,
  output logic              par_err
`endif
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF   = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  state_t            state;
  logic [IDX_W-1:0]  cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [OFF-1:0]    lane;
  logic [7:0]        mask_full;
  logic [NB-1:0]     mask;
  logic              bad;
  logic              accept;
  logic              do_store;
  logic              do_load;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] wr_shift;
  logic [DATA_W-1:0] ld_data;
  logic              unused_bits;

  // Upper address bits alias onto the array.
  assign idx         = address[OFF +: IDX_W];
  assign lane        = address[OFF-1:0];
  assign mask_full   = lane_mask(size, 3'(lane));
  assign mask        = mask_full[NB-1:0];
  assign word        = mem[idx];
  assign wr_shift    = writedata << {lane, 3'b000};
  assign unused_bits = ^{address, mask_full};

  always_comb begin
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = address[0];
      SZ_WORD: bad = |address[1:0];
      default: bad = (DATA_W != 64) || (|address[2:0]);
    endcase
  end

  assign ready    = (state == ST_IDLE);
  assign accept   = ready && (memread || memwrite);
  assign do_store = accept && memwrite && !bad;
  assign do_load  = accept && memread && !memwrite && !bad;

  dmem_load_align #(.DATA_W(DATA_W)) u_align (
    .word        (word),
    .lane        (lane),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .result      (ld_data)
  );

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] par_calc;
  logic          par_bad;

  always_comb begin
    par_calc = '0;
    for (int b = 0; b < NB; b++) par_calc[b] = ^word[8*b +: 8];
  end
  assign par_bad = |(mask & (par_calc ^ par_mem[idx]));

  always_ff @(posedge clk) begin
    if (state == ST_INIT) par_mem[cnt] <= '0;
    else if (do_store)
      for (int b = 0; b < NB; b++)
        if (mask[b]) par_mem[idx][b] <= ^wr_shift[8*b +: 8];
  end
`endif

  // Array write port: INIT clear, then byte-enabled stores.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) mem[cnt] <= '0;
    else if (do_store)
      for (int b = 0; b < NB; b++)
        if (mask[b]) mem[idx][8*b +: 8] <= wr_shift[8*b +: 8];
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      cnt      <= '0;
      readdata <= '0;
      rdvalid  <= 1'b0;
      misalign <= 1'b0;
`ifdef DMEM_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      rdvalid  <= do_load;
      misalign <= accept && bad;
      if (do_load) readdata <= ld_data;
`ifdef DMEM_PARITY_EN
      par_err  <= do_load && par_bad;
`endif
      if (state == ST_INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == IDX_W'(DEPTH - 1)) state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Randomized self-checking bench for data_memory_sized against a byte-array model.
// Parity scenario is compiled only with DMEM_PARITY_EN.
module tb_data_memory_sized;

  localparam int DEPTH = 256;
  localparam int BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] writedata = '0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        unsigned_ld = 1'b0;
  logic [31:0] readdata;
  logic        rdvalid;
  logic        ready;
  logic        misalign;
`ifdef DMEM_PARITY_EN
  logic        par_err;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0]  ref_mem [BYTES];
  logic [31:0] exp_rd = '0;

  always #5 clk = ~clk;

  data_memory_sized #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .writedata(writedata),
    .memwrite(memwrite), .memread(memread), .size(size), .unsigned_ld(unsigned_ld),
    .readdata(readdata), .rdvalid(rdvalid), .ready(ready), .misalign(misalign)
`ifdef DMEM_PARITY_EN
    , .par_err(par_err)
`endif
  );

  function automatic int nbytes(input logic [1:0] sz);
    return 1 << sz;
  endfunction

  function automatic logic model_bad(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    return (a & 32'(nbytes(sz) - 1)) != 0;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    int base = int'(a[9:0]);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[(base + i) % BYTES] = wd[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    int base = int'(a[9:0]);
    logic [31:0] v = '0;
    for (int i = 0; i < nbytes(sz); i++) v[8*i +: 8] = ref_mem[(base + i) % BYTES];
    if (!u && sz == 2'd0) v = {{24{v[7]}}, v[7:0]};
    if (!u && sz == 2'd1) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic re, input logic [1:0] sz, input logic u);
    address = a; writedata = wd; memwrite = we; memread = re; size = sz; unsigned_ld = u;
    @(posedge clk); #1;
    memwrite = 1'b0; memread = 1'b0;
  endtask

  task automatic test_reset();
    int cyc = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({ready, rdvalid, misalign} !== 3'b000 || readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_state: ready/rdvalid/misalign=%b readdata=%h, required 000 / 0", {ready, rdvalid, misalign}, readdata); end
    rst_n = 1'b1;
    model_clear();
    while (!ready && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    n_cmp++; if (cyc !== DEPTH) begin
      n_fail++; $display("FAIL init_length: got %0d cycles, required %0d", cyc, DEPTH); end
    issue(32'h14, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0);
    exp_rd = 32'h0;
    n_cmp++; if (rdvalid !== 1'b1 || readdata !== 32'h0) begin
      n_fail++; $display("FAIL post_init_load: rdvalid=%b readdata=%h, required 1 / 0", rdvalid, readdata); end
  endtask

  task automatic test_store_load();
    issue(32'h14, 32'hF14, 1'b1, 1'b0, 2'd2, 1'b0); model_store(32'h14, 32'hF14, 2'd2);
    n_cmp++; if (rdvalid !== 1'b0) begin n_fail++; $display("FAIL store_rdvalid: got %b, required 0", rdvalid); end
    issue(32'h14, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0); exp_rd = 32'h00000F14;
    n_cmp++; if (rdvalid !== 1'b1 || readdata !== exp_rd) begin
      n_fail++; $display("FAIL word_load: rdvalid=%b readdata=%h, required 1 / %h", rdvalid, readdata, exp_rd); end
    @(posedge clk); #1;
    n_cmp++; if (rdvalid !== 1'b0 || readdata !== exp_rd) begin
      n_fail++; $display("FAIL rdvalid_pulse_hold: rdvalid=%b readdata=%h, required 0 / %h", rdvalid, readdata, exp_rd); end
    issue(32'h15, 32'h9E, 1'b1, 1'b0, 2'd0, 1'b0); model_store(32'h15, 32'h9E, 2'd0);
    issue(32'h15, 32'h0, 1'b0, 1'b1, 2'd0, 1'b0);
    n_cmp++; if (readdata !== 32'hFFFFFF9E) begin n_fail++; $display("FAIL byte_signed: got %h, required ffffff9e", readdata); end
    issue(32'h15, 32'h0, 1'b0, 1'b1, 2'd0, 1'b1);
    n_cmp++; if (readdata !== 32'h0000009E) begin n_fail++; $display("FAIL byte_unsigned: got %h, required 0000009e", readdata); end
    issue(32'h14, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0); exp_rd = 32'h00009E14;
    n_cmp++; if (readdata !== exp_rd) begin n_fail++; $display("FAIL byte_merge: got %h, required %h", readdata, exp_rd); end
  endtask

  task automatic test_misalign();
    issue(32'h19, 32'h0, 1'b0, 1'b1, 2'd1, 1'b0);
    n_cmp++; if (misalign !== 1'b1 || rdvalid !== 1'b0) begin
      n_fail++; $display("FAIL half_misalign: misalign=%b rdvalid=%b, required 1 / 0", misalign, rdvalid); end
    issue(32'h1A, 32'hDEADBEEF, 1'b1, 1'b0, 2'd2, 1'b0);
    n_cmp++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL word_misalign: got %b, required 1", misalign); end
    issue(32'h18, 32'h0, 1'b0, 1'b1, 2'd3, 1'b0);
    n_cmp++; if (misalign !== 1'b1 || rdvalid !== 1'b0 || readdata !== exp_rd) begin
      n_fail++; $display("FAIL dword_illegal: misalign=%b rdvalid=%b readdata=%h, required 1 / 0 / %h", misalign, rdvalid, readdata, exp_rd); end
    @(posedge clk); #1;
    n_cmp++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse: got %b, required 0", misalign); end
    issue(32'h18, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0); exp_rd = model_load(32'h18, 2'd2, 1'b0);
    n_cmp++; if (readdata !== exp_rd || exp_rd !== 32'h0) begin
      n_fail++; $display("FAIL misalign_no_write: got %h, required 00000000", readdata); end
  endtask

  task automatic test_both();
    issue(32'h18, 32'hA, 1'b1, 1'b1, 2'd2, 1'b0); model_store(32'h18, 32'hA, 2'd2);
    n_cmp++; if (rdvalid !== 1'b0 || readdata !== exp_rd) begin
      n_fail++; $display("FAIL both_no_load: rdvalid=%b readdata=%h, required 0 / %h", rdvalid, readdata, exp_rd); end
    issue(32'h18, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0); exp_rd = 32'hA;
    n_cmp++; if (readdata !== exp_rd || rdvalid !== 1'b1) begin
      n_fail++; $display("FAIL both_stored: rdvalid=%b readdata=%h, required 1 / %h", rdvalid, readdata, exp_rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [8];
    for (int i = 0; i < 8; i++) begin
      addrs[i] = $urandom & 32'hFFFF_FFFC;
      writedata = $urandom;
      issue(addrs[i], writedata, 1'b1, 1'b0, 2'd2, 1'b0); model_store(addrs[i], writedata, 2'd2);
    end
    address = addrs[0]; size = 2'd2; unsigned_ld = 1'b0; memread = 1'b1;
    for (int i = 0; i < 8; i++) begin
      address = addrs[i];
      @(posedge clk); #1;
      exp_rd = model_load(addrs[i], 2'd2, 1'b0);
      n_cmp++; if (rdvalid !== 1'b1 || readdata !== exp_rd) begin
        n_fail++; $display("FAIL back_to_back[%0d]: rdvalid=%b readdata=%h, required 1 / %h", i, rdvalid, readdata, exp_rd); end
    end
    memread = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, wd;
      logic [1:0]  sz;
      logic        u, we, re, bad, exp_v;
      int          op;
      op = $urandom_range(0, 9);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom; wd = $urandom; u = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
      we = (op >= 4 && op <= 8);
      re = (op <= 3 || op == 8);
      bad = (we || re) && model_bad(a, sz);
      issue(a, wd, we, re, sz, u);
      exp_v = re && !we && !bad;
      if (exp_v) exp_rd = model_load(a, sz, u);
      if (we && !bad) model_store(a, wd, sz);
      n_cmp++; if (rdvalid !== exp_v || misalign !== bad || readdata !== exp_rd) begin
        n_fail++; $display("FAIL random[%0d] a=%h sz=%0d we=%b re=%b: rdvalid=%b misalign=%b readdata=%h, required %b / %b / %h",
                           i, a, sz, we, re, rdvalid, misalign, readdata, exp_v, bad, exp_rd); end
    end
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity();
    issue(32'h18, 32'h5A3C_0F11, 1'b1, 1'b0, 2'd2, 1'b0); model_store(32'h18, 32'h5A3C_0F11, 2'd2);
    issue(32'h18, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0); exp_rd = 32'h5A3C_0F11;
    n_cmp++; if (par_err !== 1'b0 || readdata !== exp_rd) begin
      n_fail++; $display("FAIL parity_clean: par_err=%b readdata=%h, required 0 / %h", par_err, readdata, exp_rd); end
    dut.mem[6][3] = ~dut.mem[6][3];
    issue(32'h18, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0); exp_rd = 32'h5A3C_0F19;
    n_cmp++; if (par_err !== 1'b1 || rdvalid !== 1'b1 || readdata !== exp_rd) begin
      n_fail++; $display("FAIL parity_error: par_err=%b rdvalid=%b readdata=%h, required 1 / 1 / %h", par_err, rdvalid, readdata, exp_rd); end
  endtask
`endif

  task automatic test_reset_mid_init();
    int cyc = 0;
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_init_ready: got %b, required 0", ready); end
    rst_n = 1'b0; #2;
    n_cmp++; if (ready !== 1'b0 || readdata !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: ready=%b readdata=%h, required 0 / 0", ready, readdata); end
    @(posedge clk); #1; rst_n = 1'b1;
    model_clear(); exp_rd = 32'h0;
    while (!ready && cyc < 1000) begin @(posedge clk); #1; cyc++; end
    n_cmp++; if (cyc !== DEPTH) begin
      n_fail++; $display("FAIL restart_init_length: got %0d cycles, required %0d", cyc, DEPTH); end
    issue(32'h14, 32'h0, 1'b0, 1'b1, 2'd2, 1'b0);
    n_cmp++; if (readdata !== 32'h0 || rdvalid !== 1'b1) begin
      n_fail++; $display("FAIL cleared_after_reset: rdvalid=%b readdata=%h, required 1 / 0", rdvalid, readdata); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misalign();
    test_both();
    test_back_to_back();
    test_random();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    test_reset_mid_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
